sram_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port 1K x 32 SRAM: instruction-fetch port (read-only) and data port (read/write, byte enables).
- Serialises accesses, drives the SRAM strobe, address, write data and byte enables, and routes the read response back to the owner.
- Inserts an idle cycle between accesses so SRAM strobes are never back-to-back. The SRAM ready flag toggles on consecutive reads, so this gap is mandatory.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arbiter_if.sv | 35 +++
 rtl/sram_arb_pick.sv | 23 ++
 rtl/sram_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-port SRAM arbiter: FSM encoding, owner ids, default widths.
package sram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side bus of the arbiter; the arbiter uses the slave modport,
// the requesters/SRAM (or a bench) use the master modport.
interface sram_arbiter_if import sram_arb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic              i_ack;
  logic [DW-1:0]     i_rdata;
  logic              d_req;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wd;
  logic [DW/8-1:0]   d_wen;
  logic              d_ack;
  logic [DW-1:0]     d_rdata;
  logic [AW-1:0]     m_a;
  logic [DW-1:0]     m_wd;
  logic [DW/8-1:0]   m_wen;
  logic              m_inp_rdy;
  logic              m_otp_rdy;
  logic [DW-1:0]     m_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wd, d_wen, m_otp_rdy, m_rd,
    output i_ack, i_rdata, d_ack, d_rdata, m_a, m_wd, m_wen, m_inp_rdy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wd, d_wen, m_otp_rdy, m_rd,
    input  i_ack, i_rdata, d_ack, d_rdata, m_a, m_wd, m_wen, m_inp_rdy
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Two-way request picker. Round-robin on last_owner by default; with
// SRAM_ARB_FIXED_PRIO_EN defined the data port always wins a tie.
module sram_arb_pick import sram_arb_pkg::*; (
  input  logic i_req,
  input  logic d_req,
`ifndef SRAM_ARB_FIXED_PRIO_EN
  input  logic last_owner,
`endif
  output logic grant_d,
  output logic any
);

  // Winner selection; grant_d is only meaningful while any=1.
  always_comb begin
    any = i_req | d_req;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    grant_d = d_req;
`else
    grant_d = d_req & (~i_req | (last_owner == OWN_I));
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter/sequencer in front of a single-port SRAM: IDLE -> ISSUE -> RESP, leaving an idle
// cycle between strobes. SRAM_ARB_FIXED_PRIO_EN selects fixed data-port priority.
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  localparam int BW = DW / 8;

  logic [1:0]    state_r;
  logic          owner_r;
  logic [AW-1:0] a_r;
  logic [DW-1:0] wd_r;
  logic [BW-1:0] wen_r;
  logic          grant_d_s;
  logic          any_s;
  logic          is_write_s;
  logic          resp_done_s;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic          last_owner_r;
`endif

  sram_arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
`ifndef SRAM_ARB_FIXED_PRIO_EN
    .last_owner (last_owner_r),
`endif
    .grant_d    (grant_d_s),
    .any        (any_s)
  );

  // A write completes without waiting; a read waits for the SRAM's valid flag.
  assign is_write_s  = |wen_r;
  assign resp_done_s = (state_r == RESP) && (is_write_s || bus.m_otp_rdy);

  // Sequencer state and latched access; requester inputs are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= OWN_I;
      a_r     <= '0;
      wd_r    <= '0;
      wen_r   <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_owner_r <= OWN_D;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r <= ISSUE;
            owner_r <= grant_d_s ? OWN_D : OWN_I;
            a_r     <= grant_d_s ? bus.d_addr : bus.i_addr;
            wd_r    <= grant_d_s ? bus.d_wd : '0;
            wen_r   <= grant_d_s ? bus.d_wen : '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_owner_r <= grant_d_s ? OWN_D : OWN_I;
`endif
          end
        end
        ISSUE: state_r <= RESP;
        RESP: begin
          if (resp_done_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Strobe and acks are gated by rst so an access caught by reset never reaches the SRAM or a requester.
  assign bus.m_inp_rdy = ~rst && (state_r == ISSUE);
  assign bus.i_ack     = ~rst && resp_done_s && (owner_r == OWN_I);
  assign bus.d_ack     = ~rst && resp_done_s && (owner_r == OWN_D);
  assign bus.i_rdata   = bus.m_rd;
  assign bus.d_rdata   = bus.m_rd;
  assign bus.m_a       = a_r;
  assign bus.m_wd      = wd_r;
  assign bus.m_wen     = wen_r;

endmodule
